clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider with 50% duty cycle for both odd and even divisors.
- Successor to the team's fixed divide-by-11 odd divider. Adds a parametrised width, a loadable divisor applied glitch-free at period boundaries, a clean start/stop enable, a boundary tick and a config error flag.
- Feeds slow-clock and strobe consumers (display scan, debouncers, baud timing) from the board clock.

---
 rtl/clk_div_prog.sv | 102 ++++++++++
 tb/tb_clk_div_prog.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable 50% duty integer clock divider
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 11
) (
    input  logic             clk_in,
    input  logic             clr_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] div_cur,
    output logic             cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx, div_nx, pend_div;
    logic             pend_vld, at_end, apply, load_ok, tick_nx, clk_p, clk_n;

    assign load_ok = div_load && (div_in >= WIDTH'(2));
    assign at_end  = (cnt == div_cur - WIDTH'(1));

    // A pending divisor only takes effect between periods, so in-flight periods never change.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        apply    = 1'b0;
        tick_nx  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                apply  = pend_vld;
                if (en) begin
                    state_nx = RUN;
                    tick_nx  = 1'b1;
                end
            end
            RUN: begin
                if (!at_end) begin
                    cnt_nx = cnt + WIDTH'(1);
                end else begin
                    cnt_nx = '0;
                    if (en) begin
                        apply   = pend_vld;
                        tick_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        endcase
        div_nx = apply ? pend_div : div_cur;
    end

    always_ff @(posedge clk_in or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_cur  <= DIV_RST;
            pend_div <= DIV_RST;
            pend_vld <= 1'b0;
            tick     <= 1'b0;
            running  <= 1'b0;
            clk_p    <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_cur <= div_nx;
            tick    <= tick_nx;
            running <= (state_nx == RUN);
            clk_p   <= (state_nx == RUN) && (cnt_nx < (div_nx >> 1));
            if (load_ok) begin
                pend_div <= div_in;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
            if (div_load) begin
                cfg_err <= ~load_ok;
            end
        end
    end

    // Half-cycle stretch of the high phase for odd divisors.
    always_ff @(negedge clk_in or negedge clr_n) begin
        if (!clr_n) begin
            clk_n <= 1'b0;
        end else begin
            clk_n <= clk_p & div_cur[0];
        end
    end

    assign clk_out = clk_p | clk_n;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

    logic       clk_in = 1'b0;
    logic       clr_n;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       clk_out, tick, running, cfg_err;
    logic [7:0] div_cur;

    int compared   = 0;
    int mismatched = 0;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(11)) dut (
        .clk_in   (clk_in),
        .clr_n    (clr_n),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running),
        .div_cur  (div_cur),
        .cfg_err  (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_tick(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            n++;
            if (tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            n++;
            if (running === 1'b0) ok = 1'b1;
        end
    endtask

    // Starts just after a tick edge; counts half-cycles high and half-cycles to the next tick.
    task automatic measure(output int hi, output int per, output bit ok);
        hi  = 0;
        per = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            per++;
            hi += int'(clk_out === 1'b1);
            @(negedge clk_in);
            #1;
            per++;
            hi += int'(clk_out === 1'b1);
            step();
            if (tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0; en = 1'b0; div_in = 8'd0; div_load = 1'b0;
        step(); step();
        compared++; if (clk_out !== 1'b0) begin mismatched++; $display("FAIL reset_clk_out got %b want 0", clk_out); end
        compared++; if (tick !== 1'b0) begin mismatched++; $display("FAIL reset_tick got %b want 0", tick); end
        compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL reset_running got %b want 0", running); end
        compared++; if (div_cur !== 8'd11) begin mismatched++; $display("FAIL reset_div_cur got %0d want 11", div_cur); end
        compared++; if (cfg_err !== 1'b0) begin mismatched++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    endtask

    task automatic test_default_div();
        int n, hi, per; bit ok;
        clr_n = 1'b1; en = 1'b1;
        wait_tick(n, ok);
        compared++; if (!ok || n != 1) begin mismatched++; $display("FAIL start_latency got %0d ok=%0b want 1", n, ok); end
        compared++; if (clk_out !== 1'b1 || running !== 1'b1) begin mismatched++; $display("FAIL start_out got clk=%b run=%b want 1 1", clk_out, running); end
        measure(hi, per, ok);
        compared++; if (!ok || hi != 11 || per != 22) begin mismatched++; $display("FAIL n11_shape got hi=%0d per=%0d want 11 22", hi, per); end
        compared++; if (div_cur !== 8'd11) begin mismatched++; $display("FAIL n11_div_cur got %0d want 11", div_cur); end
        en = 1'b0;
        wait_idle(n, ok);
        compared++; if (!ok || n != 11) begin mismatched++; $display("FAIL n11_stop got %0d want 11", n); end
    endtask

    task automatic test_load_idle();
        int n, hi, per; bit ok;
        div_in = 8'd4; div_load = 1'b1;
        step();
        div_load = 1'b0;
        compared++; if (div_cur !== 8'd11) begin mismatched++; $display("FAIL idle_pending got %0d want 11", div_cur); end
        step();
        compared++; if (div_cur !== 8'd4) begin mismatched++; $display("FAIL idle_apply got %0d want 4", div_cur); end
        en = 1'b1;
        wait_tick(n, ok);
        compared++; if (!ok || n != 1) begin mismatched++; $display("FAIL n4_start got %0d want 1", n); end
        measure(hi, per, ok);
        compared++; if (!ok || hi != 4 || per != 8) begin mismatched++; $display("FAIL n4_shape got hi=%0d per=%0d want 4 8", hi, per); end
        en = 1'b0;
        wait_idle(n, ok);
        compared++; if (!ok || n != 4) begin mismatched++; $display("FAIL n4_stop got %0d want 4", n); end
    endtask

    task automatic test_change_running();
        int n, hi, per; bit ok;
        div_in = 8'd11; div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        en = 1'b1;
        wait_tick(n, ok);
        repeat (3) step();
        div_in = 8'd7; div_load = 1'b1;
        step();
        div_load = 1'b0;
        compared++; if (div_cur !== 8'd11) begin mismatched++; $display("FAIL midload_hold got %0d want 11", div_cur); end
        wait_tick(n, ok);
        compared++; if (!ok || n != 7) begin mismatched++; $display("FAIL midload_period_end got %0d want 7", n); end
        compared++; if (div_cur !== 8'd7) begin mismatched++; $display("FAIL midload_apply got %0d want 7", div_cur); end
        measure(hi, per, ok);
        compared++; if (!ok || hi != 7 || per != 14) begin mismatched++; $display("FAIL n7_shape got hi=%0d per=%0d want 7 14", hi, per); end
    endtask

    task automatic test_cfg_err();
        int n, hi, per; bit ok;
        div_in = 8'd1; div_load = 1'b1;
        step();
        compared++; if (cfg_err !== 1'b1 || div_cur !== 8'd7) begin mismatched++; $display("FAIL err_load1 got err=%b div=%0d want 1 7", cfg_err, div_cur); end
        div_in = 8'd0;
        step();
        compared++; if (cfg_err !== 1'b1 || div_cur !== 8'd7) begin mismatched++; $display("FAIL err_load0 got err=%b div=%0d want 1 7", cfg_err, div_cur); end
        div_in = 8'd6;
        step();
        div_load = 1'b0;
        compared++; if (cfg_err !== 1'b0 || div_cur !== 8'd7) begin mismatched++; $display("FAIL err_clear got err=%b div=%0d want 0 7", cfg_err, div_cur); end
        wait_tick(n, ok);
        compared++; if (!ok || n != 4 || div_cur !== 8'd6) begin mismatched++; $display("FAIL n6_apply got n=%0d div=%0d want 4 6", n, div_cur); end
        measure(hi, per, ok);
        compared++; if (!ok || hi != 6 || per != 12) begin mismatched++; $display("FAIL n6_shape got hi=%0d per=%0d want 6 12", hi, per); end
    endtask

    task automatic test_stop_restart();
        int n; bit ok;
        div_in = 8'd5; div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_tick(n, ok);
        compared++; if (!ok || n != 5 || div_cur !== 8'd5) begin mismatched++; $display("FAIL n5_apply got n=%0d div=%0d want 5 5", n, div_cur); end
        step();
        en = 1'b0;
        wait_idle(n, ok);
        compared++; if (!ok || n != 4) begin mismatched++; $display("FAIL n5_stop got %0d want 4", n); end
        for (int i = 0; i < 3; i++) begin
            compared++; if (clk_out !== 1'b0 || tick !== 1'b0) begin mismatched++; $display("FAIL idle_quiet got clk=%b tick=%b want 0 0", clk_out, tick); end
            step();
        end
        en = 1'b1;
        step();
        compared++; if (tick !== 1'b1 || clk_out !== 1'b1 || running !== 1'b1) begin mismatched++; $display("FAIL restart got tick=%b clk=%b run=%b want 1 1 1", tick, clk_out, running); end
    endtask

    task automatic test_reset_mid();
        int n, hi, per; bit ok;
        div_in = 8'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        compared++; if (cfg_err !== 1'b1) begin mismatched++; $display("FAIL pre_reset_err got %b want 1", cfg_err); end
        #2;
        compared++; if (clk_out !== 1'b1) begin mismatched++; $display("FAIL pre_reset_high got %b want 1", clk_out); end
        clr_n = 1'b0;
        #1;
        compared++; if (clk_out !== 1'b0 || running !== 1'b0 || tick !== 1'b0) begin mismatched++; $display("FAIL async_reset got clk=%b run=%b tick=%b want 0 0 0", clk_out, running, tick); end
        compared++; if (div_cur !== 8'd11 || cfg_err !== 1'b0) begin mismatched++; $display("FAIL async_reset_cfg got div=%0d err=%b want 11 0", div_cur, cfg_err); end
        #3;
        clr_n = 1'b1;
        wait_tick(n, ok);
        compared++; if (!ok || n != 1) begin mismatched++; $display("FAIL post_reset_start got %0d want 1", n); end
        measure(hi, per, ok);
        compared++; if (!ok || hi != 11 || per != 22) begin mismatched++; $display("FAIL post_reset_shape got hi=%0d per=%0d want 11 22", hi, per); end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_load_idle();
        test_change_running();
        test_cfg_err();
        test_stop_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
